// File: rtl/sal_bk_fsm.sv
// sal_bk_fsm: per-bank controller that holds one transaction, opens and closes
// rows, tracks per-bank timing, and raises act/pre/rd/wr/ref requests for the
// scheduler until the matching grant arrives.
//
// Ports
//   clk, rst                        single clock, synchronous active-high reset
//   req_valid_i / req_ready_o       one-entry transaction handshake
//   req_wr_i, req_ra_i, req_ca_i,
//   req_id_i, req_len_i, req_seq_i  transaction fields, loaded on handshake
//   ref_req_i / ref_done_o          refresh demand pulse / tRFC-expired pulse
//   t_*_m1                          timing values minus 1 (rcd, rp, ras, rfc, wtp, rtp)
//   *_req_o / *_gnt_i               command requests to / grants from the scheduler
//   ra_o, ca_o, id_o, len_o, seq_o  fields of the held transaction (0 when empty)
//   row_open_o                      a row is open (activating or active)
//
// Build option
//   SAL_BK_CLOSE_PAGE_EN  when defined, an idle open row is precharged as soon
//                         as its timers allow (auto-close); otherwise the row
//                         stays open until a miss or a refresh.
//
// state        | meaning
// -------------+-----------------------------
// S_IDLE       | row closed
// S_ACTIVATING | tRCD running
// S_ACTIVE     | row open, CAS legal
// S_PRECHARGING| tRP running
// S_REFRESHING | tRFC running

module sal_bk_fsm #(
   parameter int RA_W  = 14,
   parameter int CA_W  = 10,
   parameter int ID_W  = 4,
   parameter int LEN_W = 4,
   parameter int SEQ_W = 8,
   parameter int TW    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_wr_i,
   input  logic [RA_W-1:0]  req_ra_i,
   input  logic [CA_W-1:0]  req_ca_i,
   input  logic [ID_W-1:0]  req_id_i,
   input  logic [LEN_W-1:0] req_len_i,
   input  logic [SEQ_W-1:0] req_seq_i,
   input  logic             ref_req_i,
   output logic             ref_done_o,
   input  logic [TW-1:0]    t_rcd_m1,
   input  logic [TW-1:0]    t_rp_m1,
   input  logic [TW-1:0]    t_ras_m1,
   input  logic [TW-1:0]    t_rfc_m1,
   input  logic [TW-1:0]    t_wtp_m1,
   input  logic [TW-1:0]    t_rtp_m1,
   output logic             act_req_o,
   output logic             pre_req_o,
   output logic             rd_req_o,
   output logic             wr_req_o,
   output logic             ref_req_o,
   output logic [RA_W-1:0]  ra_o,
   output logic [CA_W-1:0]  ca_o,
   output logic [ID_W-1:0]  id_o,
   output logic [LEN_W-1:0] len_o,
   output logic [SEQ_W-1:0] seq_o,
   input  logic             act_gnt_i,
   input  logic             pre_gnt_i,
   input  logic             rd_gnt_i,
   input  logic             wr_gnt_i,
   input  logic             ref_gnt_i,
   output logic             row_open_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVATING,
      S_ACTIVE,
      S_PRECHARGING,
      S_REFRESHING
   } state_t;

   state_t state, state_nxt;

   logic             held;
   logic             held_wr;
   logic [RA_W-1:0]  held_ra;
   logic [CA_W-1:0]  held_ca;
   logic [ID_W-1:0]  held_id;
   logic [LEN_W-1:0] held_len;
   logic [SEQ_W-1:0] held_seq;
   logic             ref_pend;
   logic [RA_W-1:0]  open_ra;
   logic             ref_done_q, ref_done_nxt;

   logic [TW-1:0] rcd_cnt, rp_cnt, ras_cnt, rfc_cnt, wtp_cnt, rtp_cnt;
   logic [TW-1:0] rcd_nxt, rp_nxt, ras_nxt, rfc_nxt, wtp_nxt, rtp_nxt;

   logic hit, timers_clr, close_req;
   logic act_fire, pre_fire, rd_fire, wr_fire, ref_fire;

   function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] c);
      return (c == '0) ? '0 : c - 1'b1;
   endfunction

   assign hit         = (held_ra == open_ra);
   assign timers_clr  = (ras_cnt == '0) && (wtp_cnt == '0) && (rtp_cnt == '0);
   assign req_ready_o = !held && !ref_pend;

`ifdef SAL_BK_CLOSE_PAGE_EN
   assign close_req = !held;
`else
   assign close_req = 1'b0;
`endif

   // Requests are pure functions of registered state, so at most one is high:
   // act/ref split on ref_pend, rd/wr on the held direction, pre needs a miss,
   // a refresh, or (auto-close) an empty holding register.
   assign act_req_o = (state == S_IDLE) && held && !ref_pend;
   assign ref_req_o = (state == S_IDLE) && ref_pend;
   assign rd_req_o  = (state == S_ACTIVE) && held && !held_wr && hit && !ref_pend;
   assign wr_req_o  = (state == S_ACTIVE) && held &&  held_wr && hit && !ref_pend;
   assign pre_req_o = (state == S_ACTIVE) && timers_clr &&
                      ((held && !hit) || ref_pend || close_req);

   // A grant only counts when its own request is up; stray grants are dropped.
   assign act_fire = act_gnt_i && act_req_o;
   assign pre_fire = pre_gnt_i && pre_req_o;
   assign rd_fire  = rd_gnt_i  && rd_req_o;
   assign wr_fire  = wr_gnt_i  && wr_req_o;
   assign ref_fire = ref_gnt_i && ref_req_o;

   assign rcd_nxt = act_fire ? t_rcd_m1 : dec_sat(rcd_cnt);
   assign ras_nxt = act_fire ? t_ras_m1 : dec_sat(ras_cnt);
   assign rp_nxt  = pre_fire ? t_rp_m1  : dec_sat(rp_cnt);
   assign rfc_nxt = ref_fire ? t_rfc_m1 : dec_sat(rfc_cnt);
   assign wtp_nxt = wr_fire  ? t_wtp_m1 : dec_sat(wtp_cnt);
   assign rtp_nxt = rd_fire  ? t_rtp_m1 : dec_sat(rtp_cnt);

   // Wait states are left when the counter's next value is zero, so the state
   // and the counter reach "done" together: a command gated on cnt==0 becomes
   // legal N cycles after its grant, with a one-cycle floor when _m1 is 0.
   always_comb begin
      state_nxt    = state;
      ref_done_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (act_fire)      state_nxt = S_ACTIVATING;
            else if (ref_fire) state_nxt = S_REFRESHING;
         end
         S_ACTIVATING: begin
            if (rcd_nxt == '0) state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (pre_fire) state_nxt = S_PRECHARGING;
         end
         S_PRECHARGING: begin
            if (rp_nxt == '0) state_nxt = S_IDLE;
         end
         S_REFRESHING: begin
            if (rfc_nxt == '0) begin
               state_nxt    = S_IDLE;
               ref_done_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         held       <= 1'b0;
         held_wr    <= 1'b0;
         held_ra    <= '0;
         held_ca    <= '0;
         held_id    <= '0;
         held_len   <= '0;
         held_seq   <= '0;
         ref_pend   <= 1'b0;
         open_ra    <= '0;
         ref_done_q <= 1'b0;
         rcd_cnt    <= '0;
         rp_cnt     <= '0;
         ras_cnt    <= '0;
         rfc_cnt    <= '0;
         wtp_cnt    <= '0;
         rtp_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         ref_done_q <= ref_done_nxt;
         rcd_cnt    <= rcd_nxt;
         rp_cnt     <= rp_nxt;
         ras_cnt    <= ras_nxt;
         rfc_cnt    <= rfc_nxt;
         wtp_cnt    <= wtp_nxt;
         rtp_cnt    <= rtp_nxt;
         if (act_fire) open_ra <= held_ra;
         if (rd_fire || wr_fire) begin
            held <= 1'b0;
         end else if (req_valid_i && req_ready_o) begin
            held     <= 1'b1;
            held_wr  <= req_wr_i;
            held_ra  <= req_ra_i;
            held_ca  <= req_ca_i;
            held_id  <= req_id_i;
            held_len <= req_len_i;
            held_seq <= req_seq_i;
         end
         // A new demand wins over a same-cycle grant; repeats are absorbed.
         if (ref_req_i)     ref_pend <= 1'b1;
         else if (ref_fire) ref_pend <= 1'b0;
      end
   end

   assign ref_done_o = ref_done_q;
   assign row_open_o = (state == S_ACTIVATING) || (state == S_ACTIVE);
   assign ra_o       = held ? held_ra  : '0;
   assign ca_o       = held ? held_ca  : '0;
   assign id_o       = held ? held_id  : '0;
   assign len_o      = held ? held_len : '0;
   assign seq_o      = held ? held_seq : '0;

endmodule

// File: tb/tb_sal_bk_fsm.sv
// Testbench for sal_bk_fsm: vector table for miss/CAS/tRAS latencies, directed
// corner sequences, and randomized traffic against a timestamp-based model.
module tb_sal_bk_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0, req_ready_o, req_wr_i = 1'b0;
   logic [13:0] req_ra_i = '0;
   logic [9:0]  req_ca_i = '0;
   logic [3:0]  req_id_i = '0, req_len_i = '0;
   logic [7:0]  req_seq_i = '0;
   logic        ref_req_i = 1'b0, ref_done_o;
   logic [5:0]  t_rcd_m1 = '0, t_rp_m1 = '0, t_ras_m1 = '0, t_rfc_m1 = '0, t_wtp_m1 = '0, t_rtp_m1 = '0;
   logic        act_req_o, pre_req_o, rd_req_o, wr_req_o, ref_req_o;
   logic [13:0] ra_o;
   logic [9:0]  ca_o;
   logic [3:0]  id_o, len_o;
   logic [7:0]  seq_o;
   logic        act_gnt_i = 1'b0, pre_gnt_i = 1'b0, rd_gnt_i = 1'b0, wr_gnt_i = 1'b0, ref_gnt_i = 1'b0;
   logic        row_open_o;

   always #5 clk = ~clk;

   sal_bk_fsm dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
      .req_ra_i(req_ra_i), .req_ca_i(req_ca_i), .req_id_i(req_id_i),
      .req_len_i(req_len_i), .req_seq_i(req_seq_i),
      .ref_req_i(ref_req_i), .ref_done_o(ref_done_o),
      .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1),
      .t_rfc_m1(t_rfc_m1), .t_wtp_m1(t_wtp_m1), .t_rtp_m1(t_rtp_m1),
      .act_req_o(act_req_o), .pre_req_o(pre_req_o), .rd_req_o(rd_req_o),
      .wr_req_o(wr_req_o), .ref_req_o(ref_req_o),
      .ra_o(ra_o), .ca_o(ca_o), .id_o(id_o), .len_o(len_o), .seq_o(seq_o),
      .act_gnt_i(act_gnt_i), .pre_gnt_i(pre_gnt_i), .rd_gnt_i(rd_gnt_i),
      .wr_gnt_i(wr_gnt_i), .ref_gnt_i(ref_gnt_i),
      .row_open_o(row_open_o)
   );

   int errors = 0;
   int checks = 0;

   localparam int S_ACT = 0, S_PRE = 1, S_RD = 2, S_WR = 3, S_REF = 4, S_DONE = 5, S_CAS = 6;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      req_valid_i = 1'b0; ref_req_i = 1'b0;
      act_gnt_i = 1'b0; pre_gnt_i = 1'b0; rd_gnt_i = 1'b0; wr_gnt_i = 1'b0; ref_gnt_i = 1'b0;
   endtask

   task automatic do_reset(input int rcd, input int rp, input int ras,
                           input int rfc, input int wtp, input int rtp);
      clear_inputs();
      t_rcd_m1 = 6'(rcd); t_rp_m1 = 6'(rp); t_ras_m1 = 6'(ras);
      t_rfc_m1 = 6'(rfc); t_wtp_m1 = 6'(wtp); t_rtp_m1 = 6'(rtp);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic sig(input int s);
      case (s)
         S_ACT:   return act_req_o;
         S_PRE:   return pre_req_o;
         S_RD:    return rd_req_o;
         S_WR:    return wr_req_o;
         S_REF:   return ref_req_o;
         S_DONE:  return ref_done_o;
         default: return rd_req_o | wr_req_o;
      endcase
   endfunction

   task automatic wait_sig(input int s, input int maxc, output int n);
      n = 0;
      while (sig(s) == 1'b0 && n < maxc) begin
         tick();
         n++;
      end
   endtask

   task automatic grant(input int s);
      case (s)
         S_ACT:   act_gnt_i = 1'b1;
         S_PRE:   pre_gnt_i = 1'b1;
         S_RD:    rd_gnt_i  = 1'b1;
         S_WR:    wr_gnt_i  = 1'b1;
         default: ref_gnt_i = 1'b1;
      endcase
      tick();
      act_gnt_i = 1'b0; pre_gnt_i = 1'b0; rd_gnt_i = 1'b0; wr_gnt_i = 1'b0; ref_gnt_i = 1'b0;
   endtask

   // nt counts every cycle spent, including the handshake cycle.
   task automatic send_req(input logic wr, input logic [13:0] ra, output int nt);
      nt = 0;
      while (!req_ready_o && nt < 50) begin
         tick();
         nt++;
      end
      req_valid_i = 1'b1; req_wr_i = wr; req_ra_i = ra;
      req_ca_i = 10'(ra + 14'd1); req_id_i = 4'h3; req_len_i = 4'h7; req_seq_i = 8'h5a;
      tick();
      nt++;
      req_valid_i = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        wr;
      logic [13:0] ra;
      int          rcd;
      int          ras;
      int          exp_cas;   // cycles from act grant to rd/wr request
      int          exp_pre;   // cycles from act grant to pre for a following miss
   } vec_t;

   vec_t vecs[5];

   // ---------------- reference model (event timestamps) ----------------
   int   tm_rcd, tm_rp, tm_ras, tm_rfc, tm_wtp, tm_rtp;
   int   m_t, m_mode, m_t_mode, m_t_rd, m_t_wr;   // mode: 0 none, 1 opened, 2 precharged, 3 refreshed
   logic m_held, m_wr, m_ref_pend;
   logic [13:0] m_ra, m_open_ra;
   logic [9:0]  m_ca;
   logic [3:0]  m_id, m_len;
   logic [7:0]  m_seq;

   function automatic int settle(input int m);
      return ((m < 1) ? 1 : m) + 1;
   endfunction

   task automatic model_reset();
      m_t = 0; m_mode = 0; m_t_mode = 0; m_t_rd = -1000; m_t_wr = -1000;
      m_held = 1'b0; m_wr = 1'b0; m_ref_pend = 1'b0; m_open_ra = '0;
      m_ra = '0; m_ca = '0; m_id = '0; m_len = '0; m_seq = '0;
   endtask

   task automatic model_step();
      logic ready_e, idle, active, hit, timers, act_e, ref_e, rd_e, wr_e, pre_e, done_e, open_e;
      logic [7:0]  got_ctl, exp_ctl;
      logic [39:0] got_f, exp_f;
      ready_e = !m_held && !m_ref_pend;
      idle    = (m_mode == 0) ||
                (m_mode == 2 && m_t >= m_t_mode + settle(tm_rp)) ||
                (m_mode == 3 && m_t >= m_t_mode + settle(tm_rfc));
      active  = (m_mode == 1) && (m_t >= m_t_mode + settle(tm_rcd));
      open_e  = (m_mode == 1);
      done_e  = (m_mode == 3) && (m_t == m_t_mode + settle(tm_rfc));
      hit     = (m_ra == m_open_ra);
      timers  = (m_t >= m_t_mode + tm_ras + 1) && (m_t >= m_t_wr + tm_wtp + 1) &&
                (m_t >= m_t_rd + tm_rtp + 1);
      act_e   = idle && m_held && !m_ref_pend;
      ref_e   = idle && m_ref_pend;
      rd_e    = active && m_held && !m_wr && hit && !m_ref_pend;
      wr_e    = active && m_held &&  m_wr && hit && !m_ref_pend;
      pre_e   = active && timers && ((m_held && !hit) || m_ref_pend);
`ifdef SAL_BK_CLOSE_PAGE_EN
      pre_e   = pre_e || (active && timers && !m_held);
`endif
      exp_ctl = {ready_e, act_e, pre_e, rd_e, wr_e, ref_e, done_e, open_e};
      got_ctl = {req_ready_o, act_req_o, pre_req_o, rd_req_o, wr_req_o, ref_req_o, ref_done_o, row_open_o};
      exp_f   = m_held ? {m_ra, m_ca, m_id, m_len, m_seq} : '0;
      got_f   = {ra_o, ca_o, id_o, len_o, seq_o};
      check("rnd_ctl", 64'(got_ctl), 64'(exp_ctl));
      check("rnd_fields", 64'(got_f), 64'(exp_f));

      req_valid_i = ($urandom_range(0, 1) == 1);
      req_wr_i    = ($urandom_range(0, 1) == 1);
      req_ra_i    = 14'($urandom_range(0, 3));
      req_ca_i    = 10'($urandom);
      req_id_i    = 4'($urandom);
      req_len_i   = 4'($urandom);
      req_seq_i   = 8'($urandom);
      ref_req_i   = ($urandom_range(0, 29) == 0);
      act_gnt_i   = ($urandom_range(0, 4) < 2);
      pre_gnt_i   = ($urandom_range(0, 4) < 2);
      rd_gnt_i    = ($urandom_range(0, 4) < 2);
      wr_gnt_i    = ($urandom_range(0, 4) < 2);
      ref_gnt_i   = ($urandom_range(0, 4) < 2);

      if (act_e && act_gnt_i) begin m_mode = 1; m_t_mode = m_t; m_open_ra = m_ra; end
      if (pre_e && pre_gnt_i) begin m_mode = 2; m_t_mode = m_t; end
      if (ref_e && ref_gnt_i) begin m_mode = 3; m_t_mode = m_t; end
      if (rd_e && rd_gnt_i) begin
         m_t_rd = m_t; m_held = 1'b0;
      end else if (wr_e && wr_gnt_i) begin
         m_t_wr = m_t; m_held = 1'b0;
      end else if (ready_e && req_valid_i) begin
         m_held = 1'b1; m_wr = req_wr_i; m_ra = req_ra_i; m_ca = req_ca_i;
         m_id = req_id_i; m_len = req_len_i; m_seq = req_seq_i;
      end
      if (ref_req_i) m_ref_pend = 1'b1;
      else if (ref_e && ref_gnt_i) m_ref_pend = 1'b0;
      tick();
      m_t++;
   endtask

   initial begin
      int   n, nt, lat;
      logic flag;

      vecs[0] = '{wr: 1'b0, ra: 14'd5, rcd: 2, ras: 7,  exp_cas: 3, exp_pre: 8};
      vecs[1] = '{wr: 1'b1, ra: 14'd9, rcd: 0, ras: 0,  exp_cas: 2, exp_pre: 4};
      vecs[2] = '{wr: 1'b0, ra: 14'd1, rcd: 1, ras: 7,  exp_cas: 2, exp_pre: 8};
      vecs[3] = '{wr: 1'b1, ra: 14'd0, rcd: 5, ras: 2,  exp_cas: 6, exp_pre: 8};
      vecs[4] = '{wr: 1'b0, ra: 14'd3, rcd: 3, ras: 12, exp_cas: 4, exp_pre: 13};

      // reset state
      do_reset(0, 0, 0, 0, 0, 0);
      check("rst_ready", req_ready_o, 1);
      check("rst_reqs", {act_req_o, pre_req_o, rd_req_o, wr_req_o, ref_req_o}, 0);
      check("rst_done_open", {ref_done_o, row_open_o}, 0);
      check("rst_fields", {ra_o, ca_o, id_o, len_o, seq_o}, 0);

      // stray grants with nothing requested
      act_gnt_i = 1; pre_gnt_i = 1; rd_gnt_i = 1; wr_gnt_i = 1; ref_gnt_i = 1;
      tick();
      clear_inputs();
      check("stray_idle_ready", req_ready_o, 1);
      check("stray_idle_state", {act_req_o, pre_req_o, rd_req_o, wr_req_o, ref_req_o, row_open_o}, 0);
      send_req(0, 14'd2, nt);
      pre_gnt_i = 1; rd_gnt_i = 1; wr_gnt_i = 1; ref_gnt_i = 1;
      tick();
      clear_inputs();
      check("stray_act_kept", {act_req_o, row_open_o, ref_req_o}, 3'b100);

      // latency table
      foreach (vecs[i]) begin
         do_reset(vecs[i].rcd, 0, vecs[i].ras, 0, 0, 0);
         send_req(vecs[i].wr, vecs[i].ra, nt);
         wait_sig(S_ACT, 20, n);
         grant(S_ACT);
         wait_sig(S_CAS, 40, n);
         lat = n + 1;
         check($sformatf("vec%0d_cas_lat", i), lat, vecs[i].exp_cas);
         check($sformatf("vec%0d_dir", i), wr_req_o, vecs[i].wr);
         check($sformatf("vec%0d_ra", i), ra_o, vecs[i].ra);
         grant(vecs[i].wr ? S_WR : S_RD);
         send_req(0, vecs[i].ra + 14'd1, nt);
         wait_sig(S_PRE, 40, n);
         check($sformatf("vec%0d_pre_lat", i), lat + 1 + nt + n, vecs[i].exp_pre);
      end

      // row hit then write-recovery-gated miss
      do_reset(2, 0, 0, 0, 3, 0);
      send_req(0, 14'd5, nt);
      wait_sig(S_ACT, 20, n);
      grant(S_ACT);
      wait_sig(S_RD, 20, n);
      grant(S_RD);
      send_req(1, 14'd5, nt);
      check("hit_wr_req", {wr_req_o, pre_req_o, act_req_o}, 3'b100);
      grant(S_WR);
      send_req(0, 14'd9, nt);
      wait_sig(S_PRE, 40, n);
      check("hit_wtp_pre_lat", 1 + nt + n, 4);

      // refresh pre-empting a held hit; second pulse is absorbed
      do_reset(1, 1, 0, 5, 0, 0);
      send_req(0, 14'd7, nt);
      wait_sig(S_ACT, 20, n);
      grant(S_ACT);
      wait_sig(S_RD, 20, n);
      check("ref_rd_before", rd_req_o, 1);
      ref_req_i = 1; tick(); ref_req_i = 0; tick();
      ref_req_i = 1; tick(); ref_req_i = 0;
      check("ref_rd_blocked", {rd_req_o, pre_req_o, req_ready_o}, 3'b010);
      grant(S_PRE);
      wait_sig(S_REF, 20, n);
      check("ref_req_seen", {ref_req_o, act_req_o}, 2'b10);
      grant(S_REF);
      wait_sig(S_DONE, 40, n);
      check("ref_done_lat", n + 1, 6);
      check("ref_absorbed", {act_req_o, ref_req_o}, 2'b10);
      check("ref_ra_held", ra_o, 14'd7);
      tick();
      check("ref_done_pulse", ref_done_o, 0);

      // reset inside REFRESHING
      do_reset(0, 0, 0, 10, 0, 0);
      ref_req_i = 1; tick(); ref_req_i = 0;
      wait_sig(S_REF, 20, n);
      grant(S_REF);
      tick(); tick();
      rst = 1; tick(); rst = 0;
      check("rstref_reqs", {act_req_o, pre_req_o, rd_req_o, wr_req_o, ref_req_o, ref_done_o}, 0);
      check("rstref_ready", req_ready_o, 1);
      flag = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         flag = flag | ref_done_o;
      end
      check("rstref_no_done", flag, 0);

      // page policy after a lone read
      do_reset(0, 0, 2, 0, 0, 1);
      send_req(0, 14'd3, nt);
      wait_sig(S_ACT, 20, n);
      grant(S_ACT);
      wait_sig(S_RD, 20, n);
      grant(S_RD);
      check("page_fields_clear", ra_o, 0);
      flag = 1'b0;
      for (int k = 0; k < 20; k++) begin
         flag = flag | pre_req_o;
         tick();
      end
`ifdef SAL_BK_CLOSE_PAGE_EN
      check("page_close_pre", flag, 1);
`else
      check("page_open_pre", flag, 0);
`endif
      check("page_row_open", row_open_o, 1);

      // randomized traffic against the model
      for (int seg = 0; seg < 4; seg++) begin
         tm_rcd = $urandom_range(0, 4); tm_rp  = $urandom_range(0, 4);
         tm_ras = $urandom_range(0, 9); tm_rfc = $urandom_range(0, 6);
         tm_wtp = $urandom_range(0, 4); tm_rtp = $urandom_range(0, 4);
         do_reset(tm_rcd, tm_rp, tm_ras, tm_rfc, tm_wtp, tm_rtp);
         model_reset();
         for (int k = 0; k < 500; k++) model_step();
      end
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
